// File: rtl/bus_pkg.sv
// Shared types and constants for the bus-cycle sequencer and its address decoder.
package bus_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CS_W   = 4;
  localparam int unsigned WAIT_W = 3;

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4} state_t;

  // IO windows live in the low 64K of IO space; both bounds inclusive
  localparam logic [15:0] IO1_BASE = 16'hFF00;
  localparam logic [15:0] IO1_LAST = 16'hFF0F;
  localparam logic [15:0] IO2_BASE = 16'h1C00;
  localparam logic [15:0] IO2_LAST = 16'h1D00;

  localparam int unsigned CS_MEM_LO = 0;
  localparam int unsigned CS_MEM_HI = 1;
  localparam int unsigned CS_IO1    = 2;
  localparam int unsigned CS_IO2    = 3;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational chip-select decode: memory splits on addr[19], IO needs addr[19:16]=0
// and a hit in one of two fixed windows.
module bus_addr_decode
  import bus_pkg::*;
(
  input  logic              req_io,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [CS_W-1:0]   cs,
  output logic              mapped
);

  logic [15:0] w_lo;
  logic        w_io_page0;

  assign w_lo       = req_addr[15:0];
  assign w_io_page0 = (req_addr[19:16] == 4'h0);

  always_comb begin
    cs = '0;
    if (!req_io) begin
      if (req_addr[19]) cs[CS_MEM_HI] = 1'b1;
      else              cs[CS_MEM_LO] = 1'b1;
    end else if (w_io_page0) begin
      if ((w_lo >= IO1_BASE) && (w_lo <= IO1_LAST))      cs[CS_IO1] = 1'b1;
      else if ((w_lo >= IO2_BASE) && (w_lo <= IO2_LAST)) cs[CS_IO2] = 1'b1;
    end
    mapped = |cs;
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// T1-T4 bus-cycle sequencer with configurable wait states. Bus pins are registered
// from the next state, so they change cleanly on the clock edge entering each phase.
module bus_cycle_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_io,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ack,
  output logic              err,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] data,
  output logic              ALE,
  output logic              RD,
  output logic              WR,
  output logic              IOM,
  output logic [CS_W-1:0]   CS
);

  localparam logic [WAIT_W-1:0] W_LAST = WAIT_W'(WAIT_STATES - 1);

  state_t              r_state, w_state_n;
  logic [WAIT_W-1:0]   r_wait, w_wait_n;
  logic                r_is_wr;
  logic [DATA_W-1:0]   r_wdata;
  logic [ADDR_W-1:0]   r_addr, w_addr_n;
  logic [CS_W-1:0]     r_cs, w_cs_n;
  logic                r_iom, w_iom_n;
  logic                r_ale, r_rd_n, r_wr_n, r_drive, r_done;
  logic [DATA_W-1:0]   r_rdata;

  logic [CS_W-1:0]     w_cs;
  logic                w_mapped;
  logic                w_accept;
  logic                w_strobe;
  logic                w_data_phase;

  bus_addr_decode u_decode (
    .req_io   (req_io),
    .req_addr (req_addr),
    .cs       (w_cs),
    .mapped   (w_mapped)
  );

  // Next state, handshake and next bus-pin values
  always_comb begin
    w_state_n = r_state;
    w_wait_n  = r_wait;
    w_accept  = 1'b0;
    ack       = 1'b0;
    err       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          ack = 1'b1;
          err = !w_mapped;
          if (w_mapped) begin
            w_accept  = 1'b1;
            w_state_n = T1;
          end
        end
      end
      T1: w_state_n = T2;
      T2: w_state_n = (WAIT_STATES == 0) ? T3 : TW;
      TW: begin
        if (r_wait == W_LAST) begin
          w_wait_n  = '0;
          w_state_n = T3;
        end else begin
          w_wait_n = r_wait + WAIT_W'(1);
        end
      end
      T3: w_state_n = T4;
      T4: w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase

    w_strobe     = (w_state_n == T2) || (w_state_n == TW) || (w_state_n == T3);
    w_data_phase = w_strobe || (w_state_n == T4);

    w_addr_n = r_addr;
    w_cs_n   = r_cs;
    w_iom_n  = r_iom;
    if (w_accept) begin
      w_addr_n = req_addr;
      w_cs_n   = w_cs;
      w_iom_n  = !req_io;
    end else if (w_state_n == IDLE) begin
      w_addr_n = '0;
      w_cs_n   = '0;
      w_iom_n  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_wait  <= '0;
      r_is_wr <= 1'b0;
      r_wdata <= '0;
      r_addr  <= '0;
      r_cs    <= '0;
      r_iom   <= 1'b1;
      r_ale   <= 1'b0;
      r_rd_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_drive <= 1'b0;
      r_done  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_n;
      r_wait  <= w_wait_n;
      r_addr  <= w_addr_n;
      r_cs    <= w_cs_n;
      r_iom   <= w_iom_n;
      if (w_accept) begin
        r_is_wr <= req_wr;
        r_wdata <= req_wdata;
      end
      r_ale   <= (w_state_n == T1);
      r_rd_n  <= !(w_strobe && !r_is_wr);
      r_wr_n  <= !(w_strobe && r_is_wr);
      r_drive <= w_data_phase && r_is_wr;
      r_done  <= (w_state_n == T4);
      // Device holds read data through T3; sample it on the edge leaving T3
      if ((r_state == T3) && !r_is_wr) r_rdata <= data;
    end
  end

  assign data    = r_drive ? r_wdata : 'z;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign Address = r_addr;
  assign ALE     = r_ale;
  assign RD      = r_rd_n;
  assign WR      = r_wr_n;
  assign IOM     = r_iom;
  assign CS      = r_cs;

endmodule
